axis_grant_mux: RTL and testbench
=================================

Name: axis_grant_mux

Overview:
- Packet-level AXI-Stream multiplexer driven by an external arbiter configured with BLOCK="ACKNOWLEDGE".
- Consumes the arbiter's grant_valid/grant_encoded and forwards one whole packet from the granted input to a single output.
- Returns a one-cycle acknowledge pulse for that port at end of packet so the arbiter can re-arbitrate.
- Sits directly downstream of the arbiter in stream-mux datapaths.

Parameters:
- PORTS, 4, number of input streams; must match the arbiter's PORTS.
- DATA_WIDTH, 8, tdata width per port.
- KEEP_ENABLE, (DATA_WIDTH>8), 1 = tkeep carried.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width per port.
- USER_ENABLE, 1, 1 = tuser carried.
- USER_WIDTH, 1, tuser width per port.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- s_axis_tdata  input  PORTS*DATA_WIDTH  concatenated input data, port 0 in LSBs
- s_axis_tkeep  input  PORTS*KEEP_WIDTH  input keep (ignored if !KEEP_ENABLE)
- s_axis_tvalid  input  PORTS  per-port valid
- s_axis_tready  output  PORTS  per-port ready
- s_axis_tlast  input  PORTS  per-port last
- s_axis_tuser  input  PORTS*USER_WIDTH  input user (ignored if !USER_ENABLE)
- grant_valid  input  1  from arbiter
- grant_encoded  input  $clog2(PORTS)  from arbiter
- acknowledge  output  PORTS  to arbiter; one-hot pulse at end of packet
- m_axis_tdata  output  DATA_WIDTH  output data
- m_axis_tkeep  output  KEEP_WIDTH  output keep (all ones if !KEEP_ENABLE)
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- m_axis_tlast  output  1  output last
- m_axis_tuser  output  USER_WIDTH  output user (zero if !USER_ENABLE)

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Reset values: state=IDLE, select=0, acknowledge=0, s_axis_tready=0, m_axis_tvalid=0, skid buffer empty. tdata/tkeep/tlast/tuser are don't-care while tvalid=0.
- States:
  - IDLE: all s_axis_tready=0. If grant_valid=1, latch select=grant_encoded and go to ACTIVE next cycle.
  - ACTIVE: s_axis_tready[select]=1 when the skid buffer has room; all other bits are 0. Beats transfer when s_axis_tvalid[select] && s_axis_tready[select]. grant inputs are ignored. An accepted beat with tlast=1 moves to ACK.
  - ACK: acknowledge = one-hot(select) for exactly this one cycle. All s_axis_tready=0. Next state is IDLE.
- Turnaround: after an ACK cycle the arbiter's grant register updates, so the IDLE cycle samples the new grant. Minimum gap between the last beat of one packet and the first accepted beat of the next is 2 idle input cycles (ACK, IDLE).
- Output stage: 2-entry skid buffer (output register + temp register).
  - s_axis_tready is registered; no combinational path from m_axis_tready to any s_axis_tready.
  - Sustains 1 beat/cycle within a packet when m_axis_tready=1.
  - Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - Data, keep, last, and user stay stable while m_axis_tvalid && !m_axis_tready.
- Single-beat packet (tlast on first beat): legal; ACTIVE lasts one transfer cycle, then ACK.
- The same port may be granted again after ACK; there is no fairness logic here, fairness is owned by the arbiter.
- grant_valid deasserting while in ACTIVE is ignored; the packet completes.
- Reset mid-packet: all state is cleared, no acknowledge is issued for the aborted packet, and skid buffer contents are discarded.
- The ACK cycle is entered only after the last beat is accepted into the skid buffer, not after it leaves m_axis.

Optional Feature:
- Macro AXIS_GRANT_MUX_TID_EN.
- When defined:
  - Adds output port m_axis_tid, width $clog2(PORTS), carrying select for every beat, registered through the skid buffer alongside the data.
  - Reset value is 0.
- When undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Basic packet: PORTS=4, grant_valid=1, grant_encoded=2, port 2 sends 3 beats 0xA1,0xA2,0xA3(last), m_axis_tready=1 -> m_axis emits A1,A2,A3 on consecutive cycles, 1 cycle after input; acknowledge=4'b0100 for exactly 1 cycle, in the cycle after A3 is accepted.
- Isolation: port 2 granted; ports 0,1,3 hold tvalid=1 -> their tready stay 0 and their data never appears on m_axis.
- Backpressure: 4-beat packet on port 1 with m_axis_tready toggling 1,0,0,1,... -> no beat lost or duplicated; output is stable while stalled; s_axis_tready[1] drops within 1 cycle of the buffer filling; acknowledge=4'b0010 is issued once.
- Back-to-back grants: grant 0 then 3, each a single-beat packet (0x11, 0x33) -> outputs 0x11 then 0x33; exactly 2 idle input cycles between acceptances; acknowledges 4'b0001 then 4'b1000.
- Reset mid-packet: port 0 sends 2 of 4 beats, rst=1 for 1 cycle -> next cycle m_axis_tvalid=0, acknowledge=0, s_axis_tready=0; a new grant afterwards forwards a fresh packet correctly.
- Tid (macro defined): grant_encoded=3, 2-beat packet -> m_axis_tid=3 on both beats.

Source files
------------

// File: rtl/axis_grant_mux.sv
// Packet mux: forwards one whole packet from the arbiter-granted port via a 2-entry skid buffer, then pulses acknowledge.
// Define AXIS_GRANT_MUX_TID_EN to add m_axis_tid, the source port of each beat.
module axis_grant_mux #(
  parameter int PORTS       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  localparam int SEL_WIDTH  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
  input  logic                        grant_valid,
  input  logic [SEL_WIDTH-1:0]        grant_encoded,
  output logic [PORTS-1:0]            acknowledge,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
`ifdef AXIS_GRANT_MUX_TID_EN
  output logic [SEL_WIDTH-1:0]        m_axis_tid,
`endif
  output logic [USER_WIDTH-1:0]       m_axis_tuser
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ACK} state_t;

  state_t                 state, state_next;
  logic [SEL_WIDTH-1:0]   select, select_next;
  logic [PORTS-1:0]       tready_next;

  logic                   in_vld;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [KEEP_WIDTH-1:0]  in_keep;
  logic                   in_last;
  logic [USER_WIDTH-1:0]  in_user;

  logic                   int_ready, int_ready_early;
  logic [KEEP_WIDTH-1:0]  out_keep;
  logic [USER_WIDTH-1:0]  out_user;

  logic                   tmp_vld;
  logic [DATA_WIDTH-1:0]  tmp_data;
  logic [KEEP_WIDTH-1:0]  tmp_keep;
  logic                   tmp_last;
  logic [USER_WIDTH-1:0]  tmp_user;
`ifdef AXIS_GRANT_MUX_TID_EN
  logic [SEL_WIDTH-1:0]   out_tid, tmp_tid;
  assign m_axis_tid = out_tid;
`endif

  assign in_vld  = s_axis_tvalid[select] & s_axis_tready[select];
  assign in_data = s_axis_tdata[select*DATA_WIDTH +: DATA_WIDTH];
  assign in_keep = s_axis_tkeep[select*KEEP_WIDTH +: KEEP_WIDTH];
  assign in_last = s_axis_tlast[select];
  assign in_user = s_axis_tuser[select*USER_WIDTH +: USER_WIDTH];

  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? out_keep : '1;
  assign m_axis_tuser = (USER_ENABLE != 0) ? out_user : '0;

  always_comb begin
    state_next  = state;
    select_next = select;
    tready_next = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          select_next = grant_encoded;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (in_vld && in_last) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Room for another beat next cycle: output drains, or temp stays free after this cycle's beat lands.
    int_ready_early = m_axis_tready || (!tmp_vld && (!m_axis_tvalid || !in_vld));
    if (state_next == ACTIVE && int_ready_early) tready_next[select_next] = 1'b1;
  end

  always_comb begin
    acknowledge = '0;
    if (state == ACK) acknowledge[select] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      select        <= '0;
      s_axis_tready <= '0;
      int_ready     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      out_keep      <= '0;
      out_user      <= '0;
      tmp_vld       <= 1'b0;
      tmp_data      <= '0;
      tmp_keep      <= '0;
      tmp_last      <= 1'b0;
      tmp_user      <= '0;
`ifdef AXIS_GRANT_MUX_TID_EN
      out_tid       <= '0;
      tmp_tid       <= '0;
`endif
    end else begin
      state         <= state_next;
      select        <= select_next;
      s_axis_tready <= tready_next;
      int_ready     <= int_ready_early;
      if (int_ready) begin
        if (m_axis_tready || !m_axis_tvalid) begin
          m_axis_tvalid <= in_vld;
          if (in_vld) begin
            m_axis_tdata <= in_data;
            out_keep     <= in_keep;
            m_axis_tlast <= in_last;
            out_user     <= in_user;
`ifdef AXIS_GRANT_MUX_TID_EN
            out_tid      <= select;
`endif
          end
        end else begin
          tmp_vld <= in_vld;
          if (in_vld) begin
            tmp_data <= in_data;
            tmp_keep <= in_keep;
            tmp_last <= in_last;
            tmp_user <= in_user;
`ifdef AXIS_GRANT_MUX_TID_EN
            tmp_tid  <= select;
`endif
          end
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= tmp_vld;
        tmp_vld       <= 1'b0;
        m_axis_tdata  <= tmp_data;
        out_keep      <= tmp_keep;
        m_axis_tlast  <= tmp_last;
        out_user      <= tmp_user;
`ifdef AXIS_GRANT_MUX_TID_EN
        out_tid       <= tmp_tid;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axis_grant_mux.sv
// Randomized + directed bench for axis_grant_mux; the bench plays the arbiter and all sources, a scoreboard checks m_axis and acknowledge.
module tb_axis_grant_mux;
  localparam int PORTS = 4;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PORTS*DW-1:0] s_axis_tdata;
  logic [PORTS-1:0]  s_axis_tkeep;
  logic [PORTS-1:0]  s_axis_tvalid;
  logic [PORTS-1:0]  s_axis_tready;
  logic [PORTS-1:0]  s_axis_tlast;
  logic [PORTS-1:0]  s_axis_tuser;
  logic              grant_valid = 1'b0;
  logic [1:0]        grant_encoded = 2'd0;
  logic [PORTS-1:0]  acknowledge;
  logic [DW-1:0]     m_axis_tdata;
  logic [0:0]        m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [0:0]        m_axis_tuser;
`ifdef AXIS_GRANT_MUX_TID_EN
  logic [1:0]        m_axis_tid;
`endif

  axis_grant_mux #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .acknowledge(acknowledge),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
`ifdef AXIS_GRANT_MUX_TID_EN
    .m_axis_tid(m_axis_tid),
`endif
    .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] dat;
    logic       last;
    logic       user;
    int         port;
    int         cyc;
  } beat_t;

  beat_t exp_q[$];
  int    ack_q[$];
  int    tests = 0;
  int    fails = 0;
  int    acc_cnt = 0;
  int    emit_cnt = 0;
  int    ready_mode = 0;
  int    cur_port = 0;
  int    first_acc = 0;
  int    last_acc = 0;
  logic [7:0] pkt[16];

  logic       drv_vld = 1'b0;
  logic [7:0] drv_dat = 8'h00;
  logic       drv_last = 1'b0;
  logic       drv_user = 1'b0;
  logic [PORTS-1:0] junk_vld = '0;

  // Non-granted ports carry recognisable junk (0xE0|port) that must never reach m_axis.
  always @(posedge clk) junk_vld <= 4'($urandom);

  always_comb begin
    s_axis_tvalid = junk_vld;
    s_axis_tlast  = '1;
    s_axis_tuser  = '1;
    s_axis_tkeep  = '1;
    for (int i = 0; i < PORTS; i++) s_axis_tdata[i*DW +: DW] = 8'hE0 | 8'(i);
    s_axis_tvalid[cur_port]            = drv_vld;
    s_axis_tlast[cur_port]             = drv_last;
    s_axis_tuser[cur_port]             = drv_user;
    s_axis_tdata[cur_port*DW +: DW]    = drv_dat;
  end

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  initial begin
    int tog = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       begin m_axis_tready = (tog % 3 == 0); tog++; end
        default: m_axis_tready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: scoreboard pops on every output handshake, plus stall, occupancy, isolation and ack checks.
  initial begin
    beat_t      e;
    int         a;
    bit         prev_stall = 1'b0;
    logic [7:0] h_dat = '0;
    logic       h_last = 1'b0;
    logic       h_user = 1'b0;
    logic [PORTS-1:0] prev_ack = '0;
    forever begin
      @(negedge clk);
      if (prev_stall)
        chk(m_axis_tvalid && m_axis_tdata == h_dat && m_axis_tlast == h_last && m_axis_tuser == h_user,
            "stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {1'b1, h_last, h_user, h_dat});
      if (m_axis_tvalid)
        chk(acc_cnt - emit_cnt <= 2, "occupancy", acc_cnt - emit_cnt, 2);
      if (m_axis_tvalid && m_axis_tready) begin
        chk(exp_q.size() != 0, "extra_beat", m_axis_tdata, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(m_axis_tdata == e.dat && m_axis_tlast == e.last && m_axis_tuser == e.user && m_axis_tkeep == 1'b1,
              "beat", {m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {1'b1, e.last, e.user, e.dat});
          if (ready_mode == 0) chk(cyc == e.cyc, "latency", cyc, e.cyc);
`ifdef AXIS_GRANT_MUX_TID_EN
          chk(int'(m_axis_tid) == e.port, "tid", m_axis_tid, e.port);
`endif
          emit_cnt++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      h_dat = m_axis_tdata; h_last = m_axis_tlast; h_user = m_axis_tuser;

      chk((s_axis_tready & ~(4'b0001 << cur_port)) == '0, "isolation", s_axis_tready, 4'b0001 << cur_port);
      if (prev_ack != '0) chk(acknowledge == '0, "ack_width", acknowledge, 0);
      else if (acknowledge != '0) begin
        chk(ack_q.size() != 0, "ack_unexpected", acknowledge, 0);
        if (ack_q.size() != 0) begin
          a = ack_q.pop_front();
          chk(acknowledge == (4'b0001 << a), "ack_port", acknowledge, 4'b0001 << a);
        end
      end
      prev_ack = acknowledge;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Acts as a BLOCK="ACKNOWLEDGE" arbiter plus the granted source; returns #1 after a posedge.
  task automatic send_pkt(input int p, input int n, input int stop_after, input bit bubbles);
    bit acc;
    int w;
    cur_port = p; grant_encoded = 2'(p); grant_valid = 1'b1;
    for (int b = 0; b < n && b < stop_after; b++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin drv_vld = 1'b0; idle(1); end
      drv_dat = pkt[b]; drv_last = (b == n - 1); drv_user = 1'($urandom); drv_vld = 1'b1;
      acc = 1'b0; w = 0;
      while (!acc && w < 200) begin
        @(negedge clk); acc = s_axis_tready[p];
        @(posedge clk); #1; w++;
      end
      chk(acc, "accept_timeout", 0, 1);
      if (!acc) begin drv_vld = 1'b0; grant_valid = 1'b0; return; end
      exp_q.push_back('{dat: drv_dat, last: drv_last, user: drv_user, port: p, cyc: cyc});
      acc_cnt++;
      if (b == 0) first_acc = cyc;
      last_acc = cyc;
      if (drv_last) ack_q.push_back(p);
    end
    drv_vld = 1'b0;
    if (stop_after >= n) begin
      @(negedge clk);
      chk(acknowledge == (4'b0001 << p), "ack_timing", acknowledge, 4'b0001 << p);
      @(posedge clk); #1;
      grant_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin @(posedge clk); #1; w++; end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk(m_axis_tvalid == 1'b0, "rst_tvalid", m_axis_tvalid, 0);
    chk(s_axis_tready == '0, "rst_tready", s_axis_tready, 0);
    chk(acknowledge == '0, "rst_ack", acknowledge, 0);
`ifdef AXIS_GRANT_MUX_TID_EN
    chk(m_axis_tid == 2'd0, "rst_tid", m_axis_tid, 0);
`endif
    @(posedge clk); #1;
    idle(2);

    // Basic 3-beat packet on port 2 with others holding junk valid.
    pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
    send_pkt(2, 3, 3, 1'b0);
    idle(3);
    drain();

    // Backpressure: 4 beats on port 1 with tready pattern 1,0,0.
    ready_mode = 1;
    pkt[0] = 8'hB1; pkt[1] = 8'hB2; pkt[2] = 8'hB3; pkt[3] = 8'hB4;
    send_pkt(1, 4, 4, 1'b0);
    drain();
    ready_mode = 0;
    idle(3);

    // Back-to-back single-beat packets: 2 idle input cycles between acceptances.
    pkt[0] = 8'h11;
    send_pkt(0, 1, 1, 1'b0);
    t0 = last_acc;
    pkt[0] = 8'h33;
    send_pkt(3, 1, 1, 1'b0);
    chk(first_acc - t0 == 3, "b2b_gap", first_acc - t0, 3);
    idle(3);
    drain();

    // Reset mid-packet after 2 of 4 beats, then a fresh packet.
    pkt[0] = 8'hC1; pkt[1] = 8'hC2; pkt[2] = 8'hC3; pkt[3] = 8'hC4;
    send_pkt(0, 4, 2, 1'b0);
    rst = 1'b1; grant_valid = 1'b0; drv_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_cnt = 0; emit_cnt = 0;
    @(negedge clk);
    chk(m_axis_tvalid == 1'b0, "midrst_tvalid", m_axis_tvalid, 0);
    chk(acknowledge == '0, "midrst_ack", acknowledge, 0);
    chk(s_axis_tready == '0, "midrst_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    pkt[0] = 8'hD1; pkt[1] = 8'hD2;
    send_pkt(3, 2, 2, 1'b0);
    idle(3);
    drain();

    // Random packets, random ports, source bubbles and random sink backpressure.
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) pkt[b] = 8'($urandom_range(0, 8'hDF));
      send_pkt($urandom_range(0, PORTS - 1), n, n, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    ready_mode = 0;
    idle(4);
    chk(ack_q.size() == 0, "ack_drain", ack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
